punc_control: RTL and testbench
===============================

// Module: punc_control
// PURPOSE
//  Control FSM for the PUnC LC3 processor. Sequences the PUnC datapath through
//  INIT -> FETCH -> DECODE -> EXECUTE[/EXECUTE2] per instruction and drives
//  every datapath load/select/enable. Decodes ir_out[15:12] and uses
//  nzp_match for BR. Exposes halt status and a retired-instruction counter.
// PARAMETERS
//  OPC_HALT   4'hF  opcode that enters HALT
//  ICNT_W     16    width of instr_count
// PORTS
//  clk              in   1   clock, rising edge
//  rst              in   1   reset: asynchronous, active-high
//  ir_out           in   16  current IR from datapath
//  nzp_match        in   1   datapath branch condition (ir[11:9] vs NZP)
//  pc_ld/pc_clr/pc_inc   out 1 each  PC load/clear/increment
//  pc_sel           out  2   0 PC+sext(ir[8:0]), 1 PC+sext(ir[10:0]), 2 Rq
//  ir_ld/ir_clr     out  1 each  IR load from dmem_r_data / clear
//  dmem_rd/dmem_wr  out  1 each  memory read strobe / write enable
//  dmem_r_addr_sel  out  2   0 PC, 1 PC+off9, 2 Rp, 3 Rq+off6
//  dmem_w_addr_sel  out  2   0 PC+off9, 1 temp, 2 Rq+off6
//  rf_w_data_sel    out  2   0 ALU, 1 PC+off9, 2 dmem_r_data, 3 PC
//  rf_w_addr_sel    out  1   0 R7, 1 ir[11:9]
//  rf_w_wr          out  1   RF write enable
//  rf_rp_addr_sel   out  1   0 ir[11:9], 1 ir[2:0]; Rq is always ir[8:6]
//  rf_rp_rd/rf_rq_rd out 1 each  RF read strobes
//  temp_ld          out  1   temp <= dmem_r_data
//  nzp_ld/nzp_clr   out  1 each  NZP update from rf_w_data / clear
//  alu_sel          out  2   0 PassA, 1 ADD, 2 AND, 3 NOT(Rq)
//  alu_in_a_sel     out  1   0 Rp data, 1 sext(ir[4:0])
//  halted           out  1   1 while in HALT
//  instr_count      out  ICNT_W  instructions retired since reset
// BEHAVIOUR
//  - All control outputs combinational from state/ir_out; default 0 each state.
//  - rst (async): state=INIT, instr_count=0. In INIT: pc_clr=ir_clr=nzp_clr=1;
//    next FETCH. Reset mid-instruction aborts it; no partial write follows.
//  - FETCH: dmem_rd=1, r_addr_sel=0, ir_ld=1 -> DECODE.
//  - DECODE: pc_inc=1 -> EXECUTE (HALT opcode -> HALT). pc_ld never with pc_inc.
//  - EXECUTE (PC already +1), writes use rf_w_addr_sel=1 unless noted:
//    ADD/AND: alu_sel 1/2, rp_sel=1, in_a_sel=ir[5], rf_w_wr, nzp_ld.
//    NOT: alu_sel=3, rf_w_wr, nzp_ld.   LEA: w_data=1, rf_w_wr, nzp_ld.
//    LD: r_addr=1, w_data=2, rf_w_wr, nzp_ld.  LDR: r_addr=3, same write.
//    LDI: r_addr=1, w_data=2, rf_w_wr (no nzp) -> EXECUTE2: rp_sel=0, r_addr=2,
//         w_data=2, rf_w_wr, nzp_ld.
//    ST: w_addr=0, rp_sel=0, dmem_wr.  STR: w_addr=2, rp_sel=0, dmem_wr.
//    STI: r_addr=1, temp_ld -> EXECUTE2: w_addr=1, rp_sel=0, dmem_wr.
//    BR: pc_ld=nzp_match, pc_sel=0.  JMP/RET: pc_sel=2, pc_ld.
//    JSR (ir[11]=1)/JSRR (0): rf_w_addr_sel=0, w_data=3, rf_w_wr, pc_ld,
//         pc_sel 1/2 - R7 gets incremented PC, PC updates same edge.
//    Unused opcode 1101/1000: no-op.
//  - EXECUTE/EXECUTE2 -> FETCH; instr_count += 1 on that edge, wraps at 2^ICNT_W.
//  - HALT: all outputs 0 except halted=1; absorbing until rst.
//  - Latency: 3 cycles/instr, 4 for LDI/STI; INIT adds 1 after reset.
// TESTING
//  1 rst pulse mid-EXECUTE of ST -> no dmem_wr after; INIT asserts 3 clears; PC=0.
//  2 mem[0]=ADD R1,R0,#5 (0x1225), mem[1]=HALT -> R1=5, P=1, instr_count=1, halted.
//  3 LDI R2 via mem[0x10]=0x20, mem[0x20]=0xBEEF -> R2=0xBEEF, N=1, 4-cycle instr.
//  4 BRz +2 with Z=1 -> PC=3; with Z=0 -> PC=1; BR nzp=000 -> unconditional.
//  5 JSR +4 at PC=5 -> R7=6, PC=10; then RET (0xC1C0) -> PC=6.
//  6 STI R3=0x1234, pointer 0x30 -> mem[0x30's value]=0x1234; NZP unchanged.

Source files
------------

// File: rtl/punc_control.sv
// Control FSM for the PUnC LC3 processor: sequences INIT/FETCH/DECODE/EXECUTE
// and drives every datapath load, select and enable from state and ir_out.
module punc_control #(
    parameter logic [3:0] OPC_HALT = 4'hF,
    parameter int unsigned ICNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       ir_out,
    input  logic              nzp_match,
    output logic              pc_ld,
    output logic              pc_clr,
    output logic              pc_inc,
    output logic [1:0]        pc_sel,
    output logic              ir_ld,
    output logic              ir_clr,
    output logic              dmem_rd,
    output logic              dmem_wr,
    output logic [1:0]        dmem_r_addr_sel,
    output logic [1:0]        dmem_w_addr_sel,
    output logic [1:0]        rf_w_data_sel,
    output logic              rf_w_addr_sel,
    output logic              rf_w_wr,
    output logic              rf_rp_addr_sel,
    output logic              rf_rp_rd,
    output logic              rf_rq_rd,
    output logic              temp_ld,
    output logic              nzp_ld,
    output logic              nzp_clr,
    output logic [1:0]        alu_sel,
    output logic              alu_in_a_sel,
    output logic              halted,
    output logic [ICNT_W-1:0] instr_count
);

    localparam logic [2:0] S_INIT     = 3'd0;
    localparam logic [2:0] S_FETCH    = 3'd1;
    localparam logic [2:0] S_DECODE   = 3'd2;
    localparam logic [2:0] S_EXECUTE  = 3'd3;
    localparam logic [2:0] S_EXECUTE2 = 3'd4;
    localparam logic [2:0] S_HALT     = 3'd5;

    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_LD  = 4'b0010;
    localparam logic [3:0] OP_ST  = 4'b0011;
    localparam logic [3:0] OP_JSR = 4'b0100;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_NOT = 4'b1001;
    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_STI = 4'b1011;
    localparam logic [3:0] OP_JMP = 4'b1100;
    localparam logic [3:0] OP_LEA = 4'b1110;

    logic [2:0] state;
    logic [2:0] state_next;
    logic [3:0] opcode;

    assign opcode = ir_out[15:12];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_INIT;
            instr_count <= '0;
        end else begin
            state <= state_next;
            if ((state == S_EXECUTE && state_next == S_FETCH) || state == S_EXECUTE2)
                instr_count <= instr_count + 1'b1;
        end
    end

    always_comb begin
        pc_ld           = 1'b0;
        pc_clr          = 1'b0;
        pc_inc          = 1'b0;
        pc_sel          = 2'd0;
        ir_ld           = 1'b0;
        ir_clr          = 1'b0;
        dmem_rd         = 1'b0;
        dmem_wr         = 1'b0;
        dmem_r_addr_sel = 2'd0;
        dmem_w_addr_sel = 2'd0;
        rf_w_data_sel   = 2'd0;
        rf_w_addr_sel   = 1'b0;
        rf_w_wr         = 1'b0;
        rf_rp_addr_sel  = 1'b0;
        rf_rp_rd        = 1'b0;
        rf_rq_rd        = 1'b0;
        temp_ld         = 1'b0;
        nzp_ld          = 1'b0;
        nzp_clr         = 1'b0;
        alu_sel         = 2'd0;
        alu_in_a_sel    = 1'b0;
        halted          = 1'b0;
        state_next      = state;

        case (state)
            S_INIT: begin
                pc_clr     = 1'b1;
                ir_clr     = 1'b1;
                nzp_clr    = 1'b1;
                state_next = S_FETCH;
            end
            S_FETCH: begin
                dmem_rd         = 1'b1;
                dmem_r_addr_sel = 2'd0;
                ir_ld           = 1'b1;
                state_next      = S_DECODE;
            end
            S_DECODE: begin
                pc_inc     = 1'b1;
                state_next = (opcode == OPC_HALT) ? S_HALT : S_EXECUTE;
            end
            S_EXECUTE: begin
                state_next = S_FETCH;
                case (opcode)
                    OP_ADD, OP_AND: begin
                        alu_sel        = (opcode == OP_ADD) ? 2'd1 : 2'd2;
                        rf_rp_addr_sel = 1'b1;
                        rf_rp_rd       = 1'b1;
                        rf_rq_rd       = 1'b1;
                        alu_in_a_sel   = ir_out[5];
                        rf_w_addr_sel  = 1'b1;
                        rf_w_wr        = 1'b1;
                        nzp_ld         = 1'b1;
                    end
                    OP_NOT: begin
                        alu_sel       = 2'd3;
                        rf_rq_rd      = 1'b1;
                        rf_w_addr_sel = 1'b1;
                        rf_w_wr       = 1'b1;
                        nzp_ld        = 1'b1;
                    end
                    OP_LEA: begin
                        rf_w_data_sel = 2'd1;
                        rf_w_addr_sel = 1'b1;
                        rf_w_wr       = 1'b1;
                        nzp_ld        = 1'b1;
                    end
                    OP_LD, OP_LDR: begin
                        dmem_rd         = 1'b1;
                        dmem_r_addr_sel = (opcode == OP_LD) ? 2'd1 : 2'd3;
                        rf_rq_rd        = (opcode == OP_LDR);
                        rf_w_data_sel   = 2'd2;
                        rf_w_addr_sel   = 1'b1;
                        rf_w_wr         = 1'b1;
                        nzp_ld          = 1'b1;
                    end
                    // DR holds the pointer after this cycle; EXECUTE2 reads through it.
                    OP_LDI: begin
                        dmem_rd         = 1'b1;
                        dmem_r_addr_sel = 2'd1;
                        rf_w_data_sel   = 2'd2;
                        rf_w_addr_sel   = 1'b1;
                        rf_w_wr         = 1'b1;
                        state_next      = S_EXECUTE2;
                    end
                    OP_ST, OP_STR: begin
                        dmem_w_addr_sel = (opcode == OP_ST) ? 2'd0 : 2'd2;
                        rf_rp_rd        = 1'b1;
                        rf_rq_rd        = (opcode == OP_STR);
                        dmem_wr         = 1'b1;
                    end
                    OP_STI: begin
                        dmem_rd         = 1'b1;
                        dmem_r_addr_sel = 2'd1;
                        temp_ld         = 1'b1;
                        state_next      = S_EXECUTE2;
                    end
                    OP_BR: begin
                        pc_sel = 2'd0;
                        pc_ld  = nzp_match;
                    end
                    OP_JMP: begin
                        pc_sel   = 2'd2;
                        pc_ld    = 1'b1;
                        rf_rq_rd = 1'b1;
                    end
                    OP_JSR: begin
                        rf_w_addr_sel = 1'b0;
                        rf_w_data_sel = 2'd3;
                        rf_w_wr       = 1'b1;
                        pc_ld         = 1'b1;
                        pc_sel        = ir_out[11] ? 2'd1 : 2'd2;
                        rf_rq_rd      = ~ir_out[11];
                    end
                    default: ;
                endcase
            end
            S_EXECUTE2: begin
                state_next = S_FETCH;
                if (opcode == OP_LDI) begin
                    dmem_rd         = 1'b1;
                    dmem_r_addr_sel = 2'd2;
                    rf_rp_rd        = 1'b1;
                    rf_w_data_sel   = 2'd2;
                    rf_w_addr_sel   = 1'b1;
                    rf_w_wr         = 1'b1;
                    nzp_ld          = 1'b1;
                end else begin
                    dmem_w_addr_sel = 2'd1;
                    rf_rp_rd        = 1'b1;
                    dmem_wr         = 1'b1;
                end
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: state_next = S_INIT;
        endcase
    end

endmodule

// File: tb/tb_punc_control.sv
// Table-driven bench for punc_control: per-opcode control words in EXECUTE/EXECUTE2,
// plus reset-abort, HALT and retired-count wrap sequences.
module tb_punc_control;

    localparam int unsigned CW = 4;

    typedef struct packed {
        logic       pc_ld;
        logic       pc_clr;
        logic       pc_inc;
        logic [1:0] pc_sel;
        logic       ir_ld;
        logic       ir_clr;
        logic       dmem_rd;
        logic       dmem_wr;
        logic [1:0] r_addr_sel;
        logic [1:0] w_addr_sel;
        logic [1:0] w_data_sel;
        logic       w_addr_r;
        logic       w_wr;
        logic       rp_sel;
        logic       rp_rd;
        logic       rq_rd;
        logic       temp_ld;
        logic       nzp_ld;
        logic       nzp_clr;
        logic [1:0] alu_sel;
        logic       a_sel;
        logic       halted;
    } ctl_t;

    typedef struct {
        string       name;
        logic [15:0] ir;
        logic        match;
        ctl_t        e1;
        logic        two;
        ctl_t        e2;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [15:0]   ir_out = '0;
    logic          nzp_match = 1'b0;
    logic          pc_ld, pc_clr, pc_inc, ir_ld, ir_clr, dmem_rd, dmem_wr;
    logic [1:0]    pc_sel, dmem_r_addr_sel, dmem_w_addr_sel, rf_w_data_sel, alu_sel;
    logic          rf_w_addr_sel, rf_w_wr, rf_rp_addr_sel, rf_rp_rd, rf_rq_rd;
    logic          temp_ld, nzp_ld, nzp_clr, alu_in_a_sel, halted;
    logic [CW-1:0] instr_count;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [CW-1:0] exp_count = '0;
    vec_t vt[$];

    punc_control #(.OPC_HALT(4'hF), .ICNT_W(CW)) dut (
        .clk(clk), .rst(rst), .ir_out(ir_out), .nzp_match(nzp_match),
        .pc_ld(pc_ld), .pc_clr(pc_clr), .pc_inc(pc_inc), .pc_sel(pc_sel),
        .ir_ld(ir_ld), .ir_clr(ir_clr), .dmem_rd(dmem_rd), .dmem_wr(dmem_wr),
        .dmem_r_addr_sel(dmem_r_addr_sel), .dmem_w_addr_sel(dmem_w_addr_sel),
        .rf_w_data_sel(rf_w_data_sel), .rf_w_addr_sel(rf_w_addr_sel), .rf_w_wr(rf_w_wr),
        .rf_rp_addr_sel(rf_rp_addr_sel), .rf_rp_rd(rf_rp_rd), .rf_rq_rd(rf_rq_rd),
        .temp_ld(temp_ld), .nzp_ld(nzp_ld), .nzp_clr(nzp_clr), .alu_sel(alu_sel),
        .alu_in_a_sel(alu_in_a_sel), .halted(halted), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    function automatic ctl_t cur();
        ctl_t c;
        c.pc_ld = pc_ld; c.pc_clr = pc_clr; c.pc_inc = pc_inc; c.pc_sel = pc_sel;
        c.ir_ld = ir_ld; c.ir_clr = ir_clr; c.dmem_rd = dmem_rd; c.dmem_wr = dmem_wr;
        c.r_addr_sel = dmem_r_addr_sel; c.w_addr_sel = dmem_w_addr_sel;
        c.w_data_sel = rf_w_data_sel; c.w_addr_r = rf_w_addr_sel; c.w_wr = rf_w_wr;
        c.rp_sel = rf_rp_addr_sel; c.rp_rd = rf_rp_rd; c.rq_rd = rf_rq_rd;
        c.temp_ld = temp_ld; c.nzp_ld = nzp_ld; c.nzp_clr = nzp_clr;
        c.alu_sel = alu_sel; c.a_sel = alu_in_a_sel; c.halted = halted;
        return c;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_ctl(input string nm, input ctl_t exp);
        chk(nm, 32'(cur()), 32'(exp));
    endtask

    task automatic add_vec(input string nm, input logic [15:0] ir, input logic m,
                           input ctl_t e1, input logic two, input ctl_t e2);
        vec_t v;
        v.name = nm; v.ir = ir; v.match = m; v.e1 = e1; v.two = two; v.e2 = e2;
        vt.push_back(v);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    ctl_t w_init, w_fetch, w_decode, w_halt, c, c2;

    initial begin
        w_init = '0;   w_init.pc_clr = 1; w_init.ir_clr = 1; w_init.nzp_clr = 1;
        w_fetch = '0;  w_fetch.dmem_rd = 1; w_fetch.ir_ld = 1;
        w_decode = '0; w_decode.pc_inc = 1;
        w_halt = '0;   w_halt.halted = 1;

        c = '0; c.alu_sel = 2'd1; c.rp_sel = 1; c.rp_rd = 1; c.rq_rd = 1;
        c.w_addr_r = 1; c.w_wr = 1; c.nzp_ld = 1;
        add_vec("add_reg", 16'h1042, 1'b0, c, 1'b0, '0);
        c.a_sel = 1;
        add_vec("add_imm", 16'h1225, 1'b0, c, 1'b0, '0);
        c.a_sel = 0; c.alu_sel = 2'd2;
        add_vec("and_reg", 16'h5042, 1'b0, c, 1'b0, '0);
        c = '0; c.alu_sel = 2'd3; c.rq_rd = 1; c.w_addr_r = 1; c.w_wr = 1; c.nzp_ld = 1;
        add_vec("not", 16'h927F, 1'b0, c, 1'b0, '0);
        c = '0; c.w_data_sel = 2'd1; c.w_addr_r = 1; c.w_wr = 1; c.nzp_ld = 1;
        add_vec("lea", 16'hE005, 1'b0, c, 1'b0, '0);
        c = '0; c.dmem_rd = 1; c.r_addr_sel = 2'd1; c.w_data_sel = 2'd2;
        c.w_addr_r = 1; c.w_wr = 1; c.nzp_ld = 1;
        add_vec("ld", 16'h2005, 1'b0, c, 1'b0, '0);
        c.r_addr_sel = 2'd3; c.rq_rd = 1;
        add_vec("ldr", 16'h6441, 1'b0, c, 1'b0, '0);
        c = '0; c.dmem_rd = 1; c.r_addr_sel = 2'd1; c.w_data_sel = 2'd2; c.w_addr_r = 1; c.w_wr = 1;
        c2 = '0; c2.dmem_rd = 1; c2.r_addr_sel = 2'd2; c2.rp_rd = 1; c2.w_data_sel = 2'd2;
        c2.w_addr_r = 1; c2.w_wr = 1; c2.nzp_ld = 1;
        add_vec("ldi", 16'hA410, 1'b0, c, 1'b1, c2);
        c = '0; c.w_addr_sel = 2'd0; c.rp_rd = 1; c.dmem_wr = 1;
        add_vec("st", 16'h3605, 1'b0, c, 1'b0, '0);
        c.w_addr_sel = 2'd2; c.rq_rd = 1;
        add_vec("str", 16'h7641, 1'b0, c, 1'b0, '0);
        c = '0; c.dmem_rd = 1; c.r_addr_sel = 2'd1; c.temp_ld = 1;
        c2 = '0; c2.w_addr_sel = 2'd1; c2.rp_rd = 1; c2.dmem_wr = 1;
        add_vec("sti", 16'hB630, 1'b0, c, 1'b1, c2);
        c = '0; c.pc_ld = 1;
        add_vec("brz_taken", 16'h0402, 1'b1, c, 1'b0, '0);
        add_vec("brz_not", 16'h0402, 1'b0, '0, 1'b0, '0);
        add_vec("br_uncond", 16'h0002, 1'b1, c, 1'b0, '0);
        c = '0; c.pc_sel = 2'd2; c.pc_ld = 1; c.rq_rd = 1;
        add_vec("ret", 16'hC1C0, 1'b0, c, 1'b0, '0);
        c = '0; c.w_data_sel = 2'd3; c.w_wr = 1; c.pc_ld = 1; c.pc_sel = 2'd1;
        add_vec("jsr", 16'h4804, 1'b0, c, 1'b0, '0);
        c.pc_sel = 2'd2; c.rq_rd = 1;
        add_vec("jsrr", 16'h4080, 1'b0, c, 1'b0, '0);
        add_vec("nop_1101", 16'hD000, 1'b1, '0, 1'b0, '0);
        add_vec("nop_1000", 16'h8000, 1'b1, '0, 1'b0, '0);

        // Reset state
        #2;
        chk_ctl("reset_init", w_init);
        chk("reset_count", 32'(instr_count), 0);
        @(negedge clk);
        rst = 1'b0;
        step();

        foreach (vt[i]) begin
            chk_ctl({vt[i].name, "_fetch"}, w_fetch);
            @(posedge clk);
            @(negedge clk);
            ir_out = vt[i].ir;
            nzp_match = vt[i].match;
            #1;
            chk_ctl({vt[i].name, "_decode"}, w_decode);
            step();
            chk_ctl({vt[i].name, "_exec"}, vt[i].e1);
            if (vt[i].two) begin
                step();
                chk_ctl({vt[i].name, "_exec2"}, vt[i].e2);
                chk({vt[i].name, "_count_mid"}, 32'(instr_count), 32'(exp_count));
            end
            step();
            exp_count = exp_count + 1'b1;
            chk({vt[i].name, "_count"}, 32'(instr_count), 32'(exp_count));
        end

        // Reset in the middle of ST's EXECUTE
        chk_ctl("st2_fetch", w_fetch);
        @(posedge clk);
        @(negedge clk);
        ir_out = 16'h3605;
        step();
        chk("st2_wr_before", 32'(dmem_wr), 1);
        rst = 1'b1;
        #1;
        chk_ctl("abort_init", w_init);
        chk("abort_count", 32'(instr_count), 0);
        exp_count = '0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_ctl("abort_init_held", w_init);
        step();
        chk_ctl("abort_fetch", w_fetch);

        // ADD then HALT
        @(posedge clk);
        @(negedge clk);
        ir_out = 16'h1225;
        step();
        step();
        chk("add_retired", 32'(instr_count), 1);
        @(posedge clk);
        @(negedge clk);
        ir_out = 16'hF025;
        #1;
        chk_ctl("halt_decode", w_decode);
        for (int k = 0; k < 5; k++) begin
            step();
            chk_ctl("halt_state", w_halt);
            chk("halt_count", 32'(instr_count), 1);
        end
        rst = 1'b1;
        #1;
        chk_ctl("halt_exit_init", w_init);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
